// File: rtl/survivor_mem_ctrl_if.sv
// Bundles the ACS write handshake, traceback read stream and status lines
// between the survivor-memory controller and the blocks around it.
interface survivor_mem_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              i_en;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic              i_flush;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_rd_first;
  logic              o_rd_dec;
  logic              o_blk_done;
  logic              o_flush_done;
  logic [ADDR_W:0]   o_occ;
  logic              o_busy;

  modport master (
    output i_en, i_wr_valid, i_flush,
    input  o_wr_ready, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_rd_first,
           o_rd_dec, o_blk_done, o_flush_done, o_occ, o_busy
  );

  modport slave (
    input  i_en, i_wr_valid, i_flush,
    output o_wr_ready, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_rd_first,
           o_rd_dec, o_blk_done, o_flush_done, o_occ, o_busy
  );
endinterface

// File: rtl/survivor_mem_ctrl.sv
// Sliding-window scheduler for the Viterbi survivor RAM: hands out write
// addresses, tracks unreleased entries and drives the traceback read stream.
module survivor_mem_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int TB_LEN  = 16,
  parameter int DEC_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  survivor_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int L     = TB_LEN + DEC_LEN;
  localparam int OCC_W = ADDR_W + 1;

  localparam logic [OCC_W-1:0]  OCC_DEPTH    = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_L        = OCC_W'(L);
  localparam logic [OCC_W-1:0]  OCC_DEC      = OCC_W'(DEC_LEN);
  localparam logic [OCC_W-1:0]  OCC_ONE      = OCC_W'(1);
  localparam logic [OCC_W-1:0]  CNT_TB_LAST  = OCC_W'(TB_LEN - 1);
  localparam logic [OCC_W-1:0]  CNT_DEC_LAST = OCC_W'(DEC_LEN - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LM1      = ADDR_W'(L - 1);
  localparam logic [ADDR_W-1:0] PTR_DEC      = ADDR_W'(DEC_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACE,
    S_DECODE,
    S_RELEASE,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rel_ptr_q, rel_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [OCC_W-1:0]  cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              first_q, first_d;

  logic wr_ready;
  logic wr_accept;
  logic rd_active;
  logic in_release;
  logic flush_last;
  logic flush_empty;

  always_comb begin : status
    wr_ready    = (occ_q < OCC_DEPTH) && !flush_pend_q;
    wr_accept   = bus.i_en && bus.i_wr_valid && wr_ready;
    rd_active   = (state_q == S_TRACE) || (state_q == S_DECODE) ||
                  (state_q == S_FLUSH);
    in_release  = (state_q == S_RELEASE);
    flush_last  = (state_q == S_FLUSH) && (cnt_q == OCC_ONE);
    flush_empty = (state_q == S_IDLE) && flush_pend_q && (occ_q == '0);
  end

  always_comb begin : next_state
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rel_ptr_d    = rel_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    first_d      = first_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      occ_d    = occ_d + OCC_ONE;
    end
    if (in_release) begin
      occ_d = occ_d - OCC_DEC;
    end
    // Writes are blocked while a flush is pending, so occ_q is the flushed count.
    if (flush_last) begin
      occ_d = occ_d - occ_q;
    end

    if (flush_last || flush_empty) begin
      flush_pend_d = 1'b0;
    end
    if (bus.i_flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (occ_q >= OCC_L) begin
          state_d  = S_TRACE;
          rd_ptr_d = rel_ptr_q + PTR_LM1;
          cnt_d    = '0;
          first_d  = 1'b1;
        end else if (flush_pend_q && (occ_q != '0)) begin
          state_d  = S_FLUSH;
          rd_ptr_d = wr_ptr_q - PTR_ONE;
          cnt_d    = occ_q;
          first_d  = 1'b1;
        end
      end
      S_TRACE: begin
        rd_ptr_d = rd_ptr_q - PTR_ONE;
        first_d  = 1'b0;
        if (cnt_q == CNT_TB_LAST) begin
          state_d = S_DECODE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + OCC_ONE;
        end
      end
      S_DECODE: begin
        rd_ptr_d = rd_ptr_q - PTR_ONE;
        if (cnt_q == CNT_DEC_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + OCC_ONE;
        end
      end
      S_RELEASE: begin
        rel_ptr_d = rel_ptr_q + PTR_DEC;
        state_d   = S_IDLE;
      end
      S_FLUSH: begin
        rd_ptr_d = rd_ptr_q - PTR_ONE;
        first_d  = 1'b0;
        cnt_d    = cnt_q - OCC_ONE;
        if (flush_last) begin
          rel_ptr_d = wr_ptr_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A low i_en freezes every register; reset still applies regardless of i_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rel_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      first_q      <= 1'b0;
    end else if (bus.i_en) begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rel_ptr_q    <= rel_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      first_q      <= first_d;
    end
  end

  assign bus.o_wr_ready   = wr_ready;
  assign bus.o_wr_en      = wr_accept;
  assign bus.o_wr_addr    = wr_ptr_q;
  assign bus.o_rd_en      = bus.i_en && rd_active;
  assign bus.o_rd_addr    = rd_ptr_q;
  assign bus.o_rd_first   = first_q && ((state_q == S_TRACE) || (state_q == S_FLUSH));
  assign bus.o_rd_dec     = (state_q == S_DECODE) || (state_q == S_FLUSH);
  assign bus.o_blk_done   = bus.i_en && in_release;
  assign bus.o_flush_done = bus.i_en && (flush_last || flush_empty);
  assign bus.o_occ        = occ_q;
  assign bus.o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_survivor_mem_ctrl.sv
// Directed bench for survivor_mem_ctrl: block reads, wrap, stall, flush,
// mid-block reset and a sustained back-pressure run.
module tb_survivor_mem_ctrl;
  localparam int ADDR_W  = 6;
  localparam int TB_LEN  = 16;
  localparam int DEC_LEN = 16;
  localparam int DEPTH   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  survivor_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  survivor_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .TB_LEN (TB_LEN),
    .DEC_LEN(DEC_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled between 2 and 5 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_en = 1'b1;
    bus.i_wr_valid = 1'b0;
    bus.i_flush = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_wr_ready", bus.o_wr_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_occ", bus.o_occ, 0);
    chk("rst_wr_en", bus.o_wr_en, 0);
    chk("rst_wr_addr", bus.o_wr_addr, 0);
    chk("rst_rd_en", bus.o_rd_en, 0);
    chk("rst_rd_addr", bus.o_rd_addr, 0);
    chk("rst_rd_first", bus.o_rd_first, 0);
    chk("rst_rd_dec", bus.o_rd_dec, 0);
    chk("rst_blk_done", bus.o_blk_done, 0);
    chk("rst_flush_done", bus.o_flush_done, 0);
    $display("reset applied");
    tick();
  endtask

  task automatic do_writes(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      bus.i_wr_valid = 1'b1;
      #1;
      chk("wr_en", bus.o_wr_en, 1);
      chk("wr_ready", bus.o_wr_ready, 1);
      chk("wr_addr", bus.o_wr_addr, (start + i) % DEPTH);
      chk("wr_no_rd", bus.o_rd_en, 0);
      tick();
    end
    bus.i_wr_valid = 1'b0;
    $display("write burst: %0d words from addr %0d", n, start);
  endtask

  task automatic expect_idle(input int occ_exp);
    #1;
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_occ", bus.o_occ, occ_exp);
    chk("idle_rd_en", bus.o_rd_en, 0);
    tick();
  endtask

  // Reads r = 0..n-1 of a block whose first address is top; optional 5-cycle i_en stall.
  task automatic read_seq(input int top, input int n, input int stall_at);
    for (int r = 0; r < n; r++) begin
      if (r == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          bus.i_en = 1'b0;
          bus.i_wr_valid = 1'b1;
          #1;
          chk("stall_rd_en", bus.o_rd_en, 0);
          chk("stall_wr_en", bus.o_wr_en, 0);
          chk("stall_rd_addr", bus.o_rd_addr, (top - r) & (DEPTH - 1));
          tick();
        end
        bus.i_en = 1'b1;
        bus.i_wr_valid = 1'b0;
      end
      #1;
      chk("rd_en", bus.o_rd_en, 1);
      chk("rd_addr", bus.o_rd_addr, (top - r) & (DEPTH - 1));
      chk("rd_dec", bus.o_rd_dec, (r >= TB_LEN) ? 1 : 0);
      chk("rd_first", bus.o_rd_first, (r == 0) ? 1 : 0);
      chk("rd_blk_done", bus.o_blk_done, 0);
      tick();
    end
    $display("read block: %0d reads from addr %0d", n, top);
  endtask

  task automatic expect_release(input int occ_before);
    #1;
    chk("rel_blk_done", bus.o_blk_done, 1);
    chk("rel_rd_en", bus.o_rd_en, 0);
    chk("rel_occ", bus.o_occ, occ_before);
    tick();
    #1;
    chk("post_occ", bus.o_occ, occ_before - DEC_LEN);
    chk("post_wr_ready", bus.o_wr_ready, 1);
    chk("post_busy", bus.o_busy, 0);
    chk("post_blk_done", bus.o_blk_done, 0);
    tick();
  endtask

  initial begin
    bus.i_en = 1'b1;
    bus.i_wr_valid = 1'b0;
    bus.i_flush = 1'b0;

    // First block, then three more so the last one wraps (rel_ptr = 48).
    do_reset();
    do_writes(32, 0);
    expect_idle(32);
    read_seq(31, 32, -1);
    expect_release(32);
    do_writes(16, 32);
    expect_idle(32);
    read_seq(47, 32, -1);
    expect_release(32);
    do_writes(16, 48);
    expect_idle(32);
    read_seq(63, 32, -1);
    expect_release(32);
    do_writes(16, 0);
    expect_idle(32);
    read_seq(15, 32, -1);
    expect_release(32);

    // i_en stall in the middle of TRACE.
    do_reset();
    do_writes(32, 0);
    expect_idle(32);
    read_seq(31, 32, 5);
    expect_release(32);

    // Flush of a partial window (occ = 20), then a flush with nothing buffered.
    do_reset();
    do_writes(20, 0);
    bus.i_flush = 1'b1;
    #1;
    chk("fl_pulse_ready", bus.o_wr_ready, 1);
    chk("fl_pulse_occ", bus.o_occ, 20);
    tick();
    bus.i_flush = 1'b0;
    bus.i_wr_valid = 1'b1;
    #1;
    chk("fl_pend_ready", bus.o_wr_ready, 0);
    chk("fl_pend_wr_en", bus.o_wr_en, 0);
    chk("fl_pend_rd_en", bus.o_rd_en, 0);
    tick();
    for (int r = 0; r < 20; r++) begin
      #1;
      chk("fl_rd_en", bus.o_rd_en, 1);
      chk("fl_rd_addr", bus.o_rd_addr, 19 - r);
      chk("fl_rd_dec", bus.o_rd_dec, 1);
      chk("fl_rd_first", bus.o_rd_first, (r == 0) ? 1 : 0);
      chk("fl_done", bus.o_flush_done, (r == 19) ? 1 : 0);
      chk("fl_wr_en", bus.o_wr_en, 0);
      tick();
    end
    bus.i_wr_valid = 1'b0;
    #1;
    chk("fl_end_occ", bus.o_occ, 0);
    chk("fl_end_ready", bus.o_wr_ready, 1);
    chk("fl_end_busy", bus.o_busy, 0);
    chk("fl_end_done", bus.o_flush_done, 0);
    $display("flush: 20 reads from addr 19");
    tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    #1;
    chk("fl0_done", bus.o_flush_done, 1);
    chk("fl0_rd_en", bus.o_rd_en, 0);
    chk("fl0_busy", bus.o_busy, 0);
    tick();
    #1;
    chk("fl0_done_clr", bus.o_flush_done, 0);
    chk("fl0_ready", bus.o_wr_ready, 1);
    $display("flush: empty window");
    tick();
    do_writes(4, 20);

    // Reset in the middle of DECODE aborts the block without a done pulse.
    do_reset();
    do_writes(32, 0);
    expect_idle(32);
    read_seq(31, 20, -1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_occ", bus.o_occ, 0);
    chk("abort_rd_en", bus.o_rd_en, 0);
    chk("abort_wr_addr", bus.o_wr_addr, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("abort_no_done", bus.o_blk_done, 0);
      chk("abort_no_rd", bus.o_rd_en, 0);
      tick();
    end
    $display("reset during decode");

    // Sustained writes for 300 cycles from an empty window.
    do_reset();
    begin
      int wa;
      wa = 0;
      for (int k = 0; k < 300; k++) begin
        int occ_e, j, b, r;
        bit rd_on, done_e, rdy_e;
        bus.i_wr_valid = 1'b1;
        if (k < 66) begin
          occ_e  = (k < 64) ? k : 64;
          rd_on  = (k >= 33) && (k <= 64);
          b      = 0;
          r      = k - 33;
          done_e = (k == 65);
        end else begin
          j      = (k - 66) % 34;
          b      = 1 + (k - 66) / 34;
          occ_e  = (j < 16) ? 48 + j : 64;
          rd_on  = (j >= 1) && (j <= 32);
          r      = j - 1;
          done_e = (j == 33);
        end
        rdy_e = (occ_e < 64);
        #1;
        chk("bp_occ", bus.o_occ, occ_e);
        chk("bp_wr_ready", bus.o_wr_ready, rdy_e);
        chk("bp_wr_en", bus.o_wr_en, rdy_e);
        chk("bp_wr_addr", bus.o_wr_addr, wa);
        chk("bp_rd_en", bus.o_rd_en, rd_on);
        chk("bp_blk_done", bus.o_blk_done, done_e);
        if (rd_on) begin
          chk("bp_rd_addr", bus.o_rd_addr, (16 * b + 31 - r) & (DEPTH - 1));
          chk("bp_rd_dec", bus.o_rd_dec, (r >= TB_LEN) ? 1 : 0);
        end
        if (done_e) $display("sustained: block %0d released at cycle %0d", b, k);
        if (rdy_e) wa = (wa + 1) % DEPTH;
        tick();
      end
      bus.i_wr_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/survivor_mem_ctrl.md
# survivor_mem_ctrl

Sliding-window scheduler for the Viterbi survivor-path memory: it assigns write addresses to ACS decision words, tracks how many unreleased entries the circular buffer holds, and sequences the traceback unit's read address stream. It sits between the ACS array (writer), the dual-port survivor RAM, and the traceback unit (reader). It also applies back-pressure to the ACS when the window is full, and drains the buffer on end-of-frame flush. The enable gating matches the decoder control FSM: one `i_en` freezes the whole block.

## Interface
- `ADDR_W`, default 6: survivor RAM address width; DEPTH = 2^ADDR_W = 64 entries.
- `TB_LEN`, default 16: traceback (convergence) reads per block, not decoded.
- `DEC_LEN`, default 16: decoded reads per block; L = TB_LEN + DEC_LEN = 32. Legal parameters require L ≤ DEPTH.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `i_en`, in, 1: global enable; 0 freezes all registers.
- `i_wr_valid`, in, 1: ACS has a decision word this cycle.
- `o_wr_ready`, out, 1: window can accept a word.
- `o_wr_en`, out, 1: RAM write strobe.
- `o_wr_addr`, out, ADDR_W: RAM write address (= wr_ptr).
- `i_flush`, in, 1: end-of-frame pulse; latched.
- `o_rd_en`, out, 1: RAM read strobe.
- `o_rd_addr`, out, ADDR_W: RAM read address.
- `o_rd_first`, out, 1: first read of a block; traceback unit loads its start state.
- `o_rd_dec`, out, 1: this read produces a decoded bit.
- `o_blk_done`, out, 1: one-cycle pulse when a normal block has been released.
- `o_flush_done`, out, 1: one-cycle pulse when a flush completes.
- `o_occ`, out, ADDR_W+1: unreleased entry count (= wr_ptr − rel_ptr).
- `o_busy`, out, 1: state ≠ IDLE.

## Operation
- Registers: wr_ptr and rel_ptr (ADDR_W bits each, wrap mod DEPTH), occ (ADDR_W+1 bits), rd_ptr, cnt, flush_pend, state.
- Write side:
  - o_wr_ready = (occ < DEPTH) & !flush_pend.
  - o_wr_en = i_en & i_wr_valid & o_wr_ready, and o_wr_addr = wr_ptr. Both are combinational.
  - On each accepted write, wr_ptr increments.
- occ update each enabled edge: occ + (write accepted) − (DEC_LEN if RELEASE) − (flush count if FLUSH end). A write and a release in the same cycle are both applied.
- FSM states: IDLE, TRACE, DECODE, RELEASE, FLUSH.
  - IDLE → TRACE when occ ≥ L. Sets rd_ptr = rel_ptr + L − 1 (mod DEPTH) and cnt = 0. This has priority over flush.
  - IDLE → FLUSH when flush_pend & occ < L & occ > 0. Sets rd_ptr = wr_ptr − 1 and cnt = occ.
  - IDLE with flush_pend & occ = 0: pulse o_flush_done, clear flush_pend, stay IDLE.
  - TRACE: o_rd_en = 1, o_rd_dec = 0. rd_ptr decrements each cycle. After TB_LEN cycles → DECODE.
  - DECODE: o_rd_en = 1, o_rd_dec = 1, rd_ptr decrements. After DEC_LEN cycles → RELEASE. The last decoded address is rel_ptr.
  - RELEASE: one cycle, no read. rel_ptr += DEC_LEN, o_blk_done = 1, → IDLE.
  - FLUSH: o_rd_en = 1, o_rd_dec = 1, decrementing for cnt cycles. On the last cycle rel_ptr = wr_ptr, o_flush_done = 1, flush_pend cleared, → IDLE.
- o_rd_first = 1 on the first read cycle of TRACE or FLUSH only.
- Flush handling:
  - i_flush sets flush_pend in any state; it is served only from IDLE after all full blocks have drained.
  - Writes are blocked while flush_pend is set.
- i_en = 0: the state and all registers hold. o_wr_en, o_rd_en, o_blk_done and o_flush_done are forced to 0. Other outputs hold their values.
- Reset state: IDLE, all pointers 0, occ 0, flush_pend 0. Output values in reset: o_wr_ready = 1, o_busy = 0, and every other output 0.

## Timing
- Read address is valid in the same cycle as o_rd_en. RAM data returns one cycle later; the traceback unit delays o_rd_first/o_rd_dec by one cycle itself.
- If the L-th write is accepted at edge N, IDLE sees occ = L in cycle N and moves to TRACE at edge N+1.
  - Reads occupy cycles N+1 … N+L.
  - RELEASE occurs in cycle N+L+1.
  - The freed space is visible to o_wr_ready in cycle N+L+2.
- Block period is L+2 cycles and yields DEC_LEN bits. Sustained ACS throughput is therefore DEC_LEN/(L+2); excess input stalls via o_wr_ready.
- The write address never equals an unreleased read address. This is guaranteed by occ ≤ DEPTH.
- Reset mid-block aborts the block immediately. No done pulse is generated.

## Test plan
- Reset, then 32 back-to-back writes → o_wr_addr 0..31. The read sequence is:
  - addresses 31..16 with o_rd_dec = 0 and o_rd_first on 31;
  - then 15..0 with o_rd_dec = 1;
  - then o_blk_done, with rel_ptr = 16.
- i_wr_valid held high for 300 cycles → o_wr_ready = 0 whenever occ = 64. occ never exceeds 64. wr_addr wraps 63→0 and no read address ever equals an in-flight write address.
- Wrap block with rel_ptr = 48 → reads 15 down through 0, 63 … 48. o_rd_dec asserts from address 63 onward.
- occ = 20, i_flush pulse → o_wr_ready drops. There are 20 reads from wr_ptr−1 downward, all with o_rd_dec = 1 and o_rd_first on the first. Then o_flush_done, occ = 0, and o_wr_ready = 1.
- i_en low for 5 cycles in mid-TRACE → no strobes during the stall. The address sequence resumes with no skipped or duplicated addresses, and the total read count is still 32.
- rst asserted mid-DECODE → the next cycle shows IDLE, occ = 0, o_rd_en = 0, and no o_blk_done pulse.
